// File: rtl/fmul_issue_queue.sv
// fmul_issue_queue: issue stage and in-order result FIFO wrapped around a
// fixed-latency, non-stalling floating-point multiplier.
//
// Requests are accepted on in_valid && in_ready. Operands go to the fmul
// through registered mul_a/mul_b. A valid/tag shift chain runs alongside the
// multiplier. When a result reaches the end of the chain, {mul_c, tag} is
// written into a DEPTH-entry FIFO. Admission is limited so that queued plus
// in-flight results never exceed DEPTH. The fmul cannot be stalled, so this
// limit is what prevents a FIFO overflow.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   in_valid/in_ready   request handshake
//   in_a, in_b, in_tag  IEEE-754 single operands and destination tag
//   mul_a, mul_b        operands driven to the fmul
//   mul_c               fmul result (the parent resets the fmul with ~rst)
//   out_valid/out_ready result handshake
//   out_data, out_tag   head-of-FIFO product and its tag
module fmul_issue_queue #(
   parameter int unsigned FMUL_LAT = 2,  // >= 1
   parameter int unsigned DEPTH    = 8,  // power of two, >= 2
   parameter int unsigned TAG_W    = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      mul_a,
   output logic [31:0]      mul_b,
   input  logic [31:0]      mul_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   // wide enough for fifo_count plus every chain stage
   localparam int unsigned SW = $clog2(DEPTH + FMUL_LAT + 2) + 1;

   logic [FMUL_LAT:0]     v;
   logic [TAG_W-1:0]      t [FMUL_LAT+1];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         fifo_count;
   logic [32+TAG_W-1:0]   mem [DEPTH];
   logic [SW-1:0]         occ;
   logic                  accept;
   logic                  push;
   logic                  pop;

   assign accept    = in_valid && in_ready;
   assign push      = v[FMUL_LAT];
   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid && out_ready;
   assign {out_data, out_tag} = mem[rd_ptr];

   // Admission depends only on registered state. Count everything already
   // committed to a FIFO slot: queued entries plus results still in the fmul.
   always_comb begin
      occ = SW'(fifo_count);
      for (int i = 0; i <= FMUL_LAT; i++) begin
         occ = occ + SW'(v[i]);
      end
   end
   assign in_ready = (occ < SW'(DEPTH));

   // Issue registers and valid chain. The chain advances every edge because
   // the fmul never stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v     <= '0;
         mul_a <= '0;
         mul_b <= '0;
      end else begin
         v <= {v[FMUL_LAT-1:0], accept};
         if (accept) begin
            mul_a <= in_a;
            mul_b <= in_b;
         end
      end
   end

   // Tags need no reset: they are qualified by v.
   always_ff @(posedge clk) begin
      if (accept) begin
         t[0] <= in_tag;
      end
      for (int i = 1; i <= FMUL_LAT; i++) begin
         t[i] <= t[i-1];
      end
   end

   // Result FIFO pointers and occupancy. The pointers wrap naturally because
   // DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         assert (!(push && !pop && fifo_count == CW'(DEPTH)));
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {mul_c, t[FMUL_LAT]};
      end
   end

endmodule

// File: doc/fmul_issue_queue.md
FMUL_ISSUE_QUEUE -- requirements
Module: fmul_issue_queue

Interface
REQ-001 The block SHALL have parameter FMUL_LAT, default 2, meaning the fmul cycles from operand-sample edge to result-register edge.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning result FIFO entries (power of two, >= 2).
REQ-003 The block SHALL have parameter TAG_W, default 6, meaning destination tag width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  request can be accepted.
REQ-008 in_a, in_b  in  32 each  IEEE-754 single operands.
REQ-009 in_tag  in  TAG_W  destination tag.
REQ-010 mul_a, mul_b  out  32 each  operands driven to fmul a/b.
REQ-011 mul_c  in  32  fmul result c.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 out_data  out  32  product.
REQ-015 out_tag  out  TAG_W  tag matching out_data.

Function
REQ-016 Accept SHALL occur on an edge with in_valid && in_ready; mul_a/mul_b/issue tag SHALL register in_a/in_b/in_tag and valid bit v[0] SHALL set.
REQ-017 Without accept, v[0] SHALL clear; mul_a/mul_b SHALL hold their last value.
REQ-018 A tag/valid shift chain v[0..FMUL_LAT] with tags t[0..FMUL_LAT] SHALL advance one stage per edge, unconditionally (fmul never stalls).
REQ-019 When v[FMUL_LAT]=1, the next edge SHALL write {mul_c, t[FMUL_LAT]} into the FIFO.
REQ-020 Latency, accept edge to out_valid high with empty FIFO, SHALL be FMUL_LAT+1 cycles (3 at default).
REQ-021 inflight = popcount(v[0..FMUL_LAT]); in_ready SHALL be (fifo_count + inflight) < DEPTH, registered state only, no combinational path from out_ready.
REQ-022 The FIFO SHALL never overflow; a write with fifo_count == DEPTH is an assertion failure.
REQ-023 out_valid SHALL equal (fifo_count != 0); out_data/out_tag SHALL show the head entry; pop SHALL occur on edges with out_valid && out_ready.
REQ-024 Simultaneous push and pop SHALL leave fifo_count unchanged and be lossless, including at fifo_count == 1.
REQ-025 Read/write pointers SHALL be log2(DEPTH) bits and wrap DEPTH-1 -> 0.
REQ-026 Results SHALL leave in acceptance order; out_data/out_tag SHALL be stable while out_valid && !out_ready.
REQ-027 With out_ready held high, sustained throughput SHALL be one result per cycle at default parameters.
REQ-028 No arithmetic is performed on data; products (including fmul zero-flush) pass bit-exact.

Reset
REQ-029 rst low SHALL immediately clear v[], fifo_count, pointers, mul_a, mul_b, out_valid; in_ready SHALL be 1 after release.
REQ-030 Reset mid-operation SHALL discard in-flight and queued results; a stale mul_c after release SHALL NOT be written because v[] is clear.
REQ-031 fmul's own reset SHALL be driven as the inverse of rst by the parent.

Verification
REQ-032 Single op: 0x40000000 x 0x40400000 tag 5 -> out_valid on third edge after accept, out_data 0x40C00000, out_tag 5.
REQ-033 Stream 0x3FC00000^2 (tag 1), 0xC0000000 x 0x40400000 (tag 2), 0x00000000 x 0x40400000 (tag 3), out_ready=1 -> 0x40100000/1, 0xC0C00000/2, 0x00000000/3 on consecutive cycles.
REQ-034 out_ready=0, in_valid=1 continuously -> exactly 8 accepts then in_ready=0; raise out_ready -> 8 results in order, tags 0..7.
REQ-035 Fill to fifo_count 1 with inflight results arriving while out_ready=1 -> simultaneous push/pop, no loss, pointers wrap past 7.
REQ-036 Assert rst with 3 in flight and 4 queued -> out_valid=0 at once; after release no output until new accepts.
